// File: rtl/mem_ctrl_simple_pkg.sv
// -----------------------------------------------------------------------------
// global_defs
//   Shared definitions for the cache-to-main-memory block protocol: the request
//   type seen on the dcache port, block address/data types, the default memory
//   geometry and latency, and the controller's internal enumerations.
//   No ports (package).
// -----------------------------------------------------------------------------
package global_defs;

  localparam int DEF_N_BLOCKS    = 1024;
  localparam int DEF_BLOCK_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH  = $clog2(DEF_N_BLOCKS);
  localparam int DEF_MEM_LATENCY = 10;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef logic [DEF_ADDR_WIDTH-1:0]  main_mem_block_addr_t;
  typedef logic [DEF_BLOCK_WIDTH-1:0] block_data_t;

  // Which cache issued the transaction currently in flight.
  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/mem_ctrl_simple_mem.sv
// -----------------------------------------------------------------------------
// main_mem_array
//   Synchronous single-port block RAM (N_BLOCKS x BLOCK_WIDTH) with a registered
//   read port. A write updates the array and also places the written block on
//   the read register, so the controller can return either a read or a write
//   echo from the same register.
//
// Ports
//   clk      : clock
//   rst_aL   : synchronous active-low reset (clears the read register only)
//   i_en     : access enable for this cycle
//   i_we     : 1 = write, 0 = read (qualified by i_en)
//   i_addr   : block address
//   i_wdata  : block write data
//   o_rdata  : registered read data / write echo
// -----------------------------------------------------------------------------
module main_mem_array #(
  parameter int N_BLOCKS    = 1024,
  parameter int BLOCK_WIDTH = 64,
  parameter int ADDR_WIDTH  = $clog2(N_BLOCKS)
) (
  input  logic                   clk,
  input  logic                   rst_aL,
  input  logic                   i_en,
  input  logic                   i_we,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [BLOCK_WIDTH-1:0] i_wdata,
  output logic [BLOCK_WIDTH-1:0] o_rdata
);

  logic [BLOCK_WIDTH-1:0] r_mem [N_BLOCKS];
  logic [BLOCK_WIDTH-1:0] r_rdata;

  // NOTE: the storage array has no reset branch on purpose; resetting a RAM
  // would turn it into a huge flop array. Its contents survive rst_aL.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // The read register is an ordinary output flop and is cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= i_we ? i_wdata : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_ctrl_simple.sv
// -----------------------------------------------------------------------------
// mem_ctrl_simple
//   Responder end of the cache-to-memory block protocol. Arbitrates between the
//   icache (read-only) and the dcache (read/write) with icache priority, serves
//   one request at a time against main_mem_array after MEM_LATENCY cycles, and
//   returns a one-cycle response pulse to whichever cache issued the request.
//
// Ports
//   clk, rst_aL               : clock, synchronous active-low reset
//   icache_req_valid/_addr    : icache read request
//   icache_req_ready          : icache request accepted this cycle
//   icache_resp_valid/_data   : one-cycle icache read response
//   dcache_req_valid/_type    : dcache request, READ or WRITE
//   dcache_req_block_addr/data: dcache address and write data
//   dcache_req_ready          : dcache request accepted this cycle
//   dcache_resp_valid/_data   : one-cycle dcache response (read data or echo)
// -----------------------------------------------------------------------------
module mem_ctrl_simple
  import global_defs::*;
#(
  parameter int N_BLOCKS    = DEF_N_BLOCKS,
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int ADDR_WIDTH  = $clog2(N_BLOCKS),
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst_aL,

  input  logic                   icache_req_valid,
  input  logic [ADDR_WIDTH-1:0]  icache_req_block_addr,
  output logic                   icache_req_ready,
  output logic                   icache_resp_valid,
  output logic [BLOCK_WIDTH-1:0] icache_resp_block_data,

  input  logic                   dcache_req_valid,
  input  req_type_t              dcache_req_type,
  input  logic [ADDR_WIDTH-1:0]  dcache_req_block_addr,
  input  logic [BLOCK_WIDTH-1:0] dcache_req_block_data,
  output logic                   dcache_req_ready,
  output logic                   dcache_resp_valid,
  output logic [BLOCK_WIDTH-1:0] dcache_resp_block_data
);

  // The counter holds at most MEM_LATENCY-2, which always fits in this width.
  localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

  ctrl_state_t            r_state;
  logic [CNT_W-1:0]       r_cnt;
  req_id_t                r_id;
  req_type_t              r_type;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BLOCK_WIDTH-1:0] r_wdata;
  logic                   r_icache_resp_valid;
  logic                   r_dcache_resp_valid;

  logic                   w_idle;
  logic                   w_ic_accept;
  logic                   w_dc_accept;
  logic                   w_commit;
  logic [BLOCK_WIDTH-1:0] w_rd_data;

  // Readies are gated by rst_aL so nothing looks acceptable while reset is held.
  assign w_idle           = rst_aL && (r_state == ST_IDLE);
  assign icache_req_ready = w_idle;
  assign dcache_req_ready = w_idle && !icache_req_valid;

  assign w_ic_accept = icache_req_valid && icache_req_ready;
  assign w_dc_accept = dcache_req_valid && dcache_req_ready;

  // Memory access happens on the BUSY -> RESP edge; a reset arriving on that
  // same edge suppresses the write so an aborted transaction never lands.
  assign w_commit = rst_aL && (r_state == ST_BUSY) && (r_cnt == '0);

  main_mem_array #(
    .N_BLOCKS   (N_BLOCKS),
    .BLOCK_WIDTH(BLOCK_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .rst_aL (rst_aL),
    .i_en   (w_commit),
    .i_we   (r_type == WRITE),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_rd_data)
  );

  // NOTE: every register in this block is assigned with <= so that all state
  // updates within one edge see the pre-edge values, independent of order.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      r_state             <= ST_IDLE;
      r_cnt               <= '0;
      r_id                <= REQ_ICACHE;
      r_type              <= READ;
      r_addr              <= '0;
      r_wdata             <= '0;
      r_icache_resp_valid <= 1'b0;
      r_dcache_resp_valid <= 1'b0;
    end else begin
      r_icache_resp_valid <= 1'b0;
      r_dcache_resp_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_ic_accept) begin
            r_state <= ST_BUSY;
            r_cnt   <= CNT_W'(MEM_LATENCY - 2);
            r_id    <= REQ_ICACHE;
            r_type  <= READ;
            r_addr  <= icache_req_block_addr;
            r_wdata <= '0;
          end else if (w_dc_accept) begin
            r_state <= ST_BUSY;
            r_cnt   <= CNT_W'(MEM_LATENCY - 2);
            r_id    <= REQ_DCACHE;
            r_type  <= dcache_req_type;
            r_addr  <= dcache_req_block_addr;
            r_wdata <= dcache_req_block_data;
          end
        end

        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state             <= ST_RESP;
            r_icache_resp_valid <= (r_id == REQ_ICACHE);
            r_dcache_resp_valid <= (r_id == REQ_DCACHE);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign icache_resp_valid      = r_icache_resp_valid;
  assign dcache_resp_valid      = r_dcache_resp_valid;
  // Both data buses carry the memory read register; each is qualified by its
  // own resp_valid pulse.
  assign icache_resp_block_data = w_rd_data;
  assign dcache_resp_block_data = w_rd_data;

endmodule

// File: tb/tb_mem_ctrl_simple.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_simple
//   Self-checking bench for mem_ctrl_simple: directed scenarios followed by
//   randomized traffic, compared against a transaction-level reference memory.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_simple;
  import global_defs::*;

  localparam int N  = 1024;
  localparam int BW = 64;
  localparam int AW = 10;
  localparam int L  = 10;

  logic          clk = 1'b0;
  logic          rst_aL = 1'b0;
  logic          icache_req_valid = 1'b0;
  logic [AW-1:0] icache_req_block_addr = '0;
  logic          icache_req_ready;
  logic          icache_resp_valid;
  logic [BW-1:0] icache_resp_block_data;
  logic          dcache_req_valid = 1'b0;
  req_type_t     dcache_req_type = READ;
  logic [AW-1:0] dcache_req_block_addr = '0;
  logic [BW-1:0] dcache_req_block_data = '0;
  logic          dcache_req_ready;
  logic          dcache_resp_valid;
  logic [BW-1:0] dcache_resp_block_data;

  mem_ctrl_simple #(
    .N_BLOCKS   (N),
    .BLOCK_WIDTH(BW),
    .MEM_LATENCY(L)
  ) u_dut (
    .clk                   (clk),
    .rst_aL                (rst_aL),
    .icache_req_valid      (icache_req_valid),
    .icache_req_block_addr (icache_req_block_addr),
    .icache_req_ready      (icache_req_ready),
    .icache_resp_valid     (icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid      (dcache_req_valid),
    .dcache_req_type       (dcache_req_type),
    .dcache_req_block_addr (dcache_req_block_addr),
    .dcache_req_block_data (dcache_req_block_data),
    .dcache_req_ready      (dcache_req_ready),
    .dcache_resp_valid     (dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference view of main memory, updated once per committed write.
  logic [BW-1:0] ref_mem [N];

  // Requester-side intent: what each cache is currently presenting.
  bit            ic_v;
  logic [AW-1:0] ic_addr;
  bit            dc_pend;
  req_type_t     dc_type;
  logic [AW-1:0] dc_addr;
  logic [BW-1:0] dc_data;

  // Optional dcache request raised while a transaction is in flight.
  int            inj_k;
  req_type_t     inj_type;
  logic [AW-1:0] inj_addr;
  logic [BW-1:0] inj_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive();
    icache_req_valid      = ic_v;
    icache_req_block_addr = ic_addr;
    dcache_req_valid      = dc_pend;
    dcache_req_type       = dc_type;
    dcache_req_block_addr = dc_addr;
    dcache_req_block_data = dc_data;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return AW'(0);
      1:       return AW'(N - 1);
      2:       return AW'($urandom_range(0, 7));
      default: return AW'($urandom_range(0, N - 1));
    endcase
  endfunction

  function automatic logic [BW-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  // One full transaction, starting in an IDLE cycle. Icache wins whenever it
  // is valid; the response must appear exactly L cycles after acceptance.
  task automatic serve_one();
    bit            win_ic;
    req_type_t     t;
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    logic [BW-1:0] exp_d;

    @(negedge clk);
    drive();
    #1;
    check("ic_ready_idle", 64'(icache_req_ready), 64'(1));
    check("dc_ready_idle", 64'(dcache_req_ready), 64'(!ic_v));

    win_ic = ic_v;
    if (win_ic) begin
      t = READ;    a = ic_addr; d = '0;
    end else begin
      t = dc_type; a = dc_addr; d = dc_data;
    end
    exp_d = (t == WRITE) ? d : ref_mem[a];
    if (t == WRITE) ref_mem[a] = d;

    @(posedge clk);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (win_ic) ic_v = 1'b0;
        else        dc_pend = 1'b0;
      end
      if (k == inj_k && !dc_pend) begin
        dc_pend = 1'b1; dc_type = inj_type; dc_addr = inj_addr; dc_data = inj_data;
      end
      drive();
      #1;
      check("ic_ready_busy", 64'(icache_req_ready), 64'(0));
      check("dc_ready_busy", 64'(dcache_req_ready), 64'(0));
      if (k < L) begin
        check("ic_resp_early", 64'(icache_resp_valid), 64'(0));
        check("dc_resp_early", 64'(dcache_resp_valid), 64'(0));
      end else begin
        check("ic_resp_valid", 64'(icache_resp_valid), 64'(win_ic));
        check("dc_resp_valid", 64'(dcache_resp_valid), 64'(!win_ic));
        if (win_ic) check("ic_resp_data", icache_resp_block_data, exp_d);
        else        check("dc_resp_data", dcache_resp_block_data, exp_d);
      end
    end
    inj_k = 0;
  endtask

  initial begin
    // Preload main memory and mirror it in the reference model.
    for (int i = 0; i < N; i++) begin
      ref_mem[i] = rand_data();
      u_dut.u_mem.r_mem[i] = ref_mem[i];
    end
    ref_mem[5] = 64'hDEADBEEF_01234567;
    u_dut.u_mem.r_mem[5] = ref_mem[5];

    ic_v = 0; ic_addr = '0; dc_pend = 0; dc_type = READ; dc_addr = '0; dc_data = '0;
    inj_k = 0; inj_type = READ; inj_addr = '0; inj_data = '0;
    drive();

    // Reset held for two cycles, then idle with readies up.
    rst_aL = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ic_resp_valid", 64'(icache_resp_valid), 64'(0));
    check("rst_dc_resp_valid", 64'(dcache_resp_valid), 64'(0));
    check("rst_ic_ready", 64'(icache_req_ready), 64'(0));
    check("rst_dc_ready", 64'(dcache_req_ready), 64'(0));
    check("rst_ic_data", icache_resp_block_data, 64'(0));
    check("rst_dc_data", dcache_resp_block_data, 64'(0));
    rst_aL = 1'b1;
    #1;
    check("idle_ic_ready", 64'(icache_req_ready), 64'(1));
    check("idle_dc_ready", 64'(dcache_req_ready), 64'(1));

    // Icache read of the preloaded block.
    ic_v = 1; ic_addr = AW'(5);
    serve_one();

    // Dcache write to the top block, then read it back.
    dc_pend = 1; dc_type = WRITE; dc_addr = AW'(N - 1); dc_data = {32'hA5A5A5A5, 32'hA5A5A5A5};
    serve_one();
    dc_pend = 1; dc_type = READ; dc_addr = AW'(N - 1); dc_data = '0;
    serve_one();

    // Simultaneous requests: icache first, dcache right after the icache RESP.
    ic_v = 1; ic_addr = AW'(3);
    dc_pend = 1; dc_type = READ; dc_addr = AW'(4); dc_data = '0;
    serve_one();
    serve_one();

    // Dcache write raised mid-flight is held off, then lands exactly once.
    ic_v = 1; ic_addr = AW'(9);
    inj_k = 4; inj_type = WRITE; inj_addr = AW'(9); inj_data = 64'h0123_4567_89AB_CDEF;
    serve_one();
    serve_one();
    ic_v = 1; ic_addr = AW'(9);
    serve_one();

    // Reset in the middle of a write: no response, memory untouched.
    dc_pend = 1; dc_type = WRITE; dc_addr = AW'(7); dc_data = ~ref_mem[7];
    @(negedge clk);
    drive();
    #1;
    check("rw_dc_ready", 64'(dcache_req_ready), 64'(1));
    @(posedge clk);
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      if (k == 1) dc_pend = 0;
      if (k == 5) rst_aL = 1'b0;
      if (k == 7) rst_aL = 1'b1;
      drive();
      #1;
      check("rw_no_dc_resp", 64'(dcache_resp_valid), 64'(0));
      check("rw_no_ic_resp", 64'(icache_resp_valid), 64'(0));
    end
    dc_pend = 1; dc_type = READ; dc_addr = AW'(7); dc_data = '0;
    serve_one();

    // Randomized traffic.
    repeat (40) begin
      ic_v = ($urandom_range(0, 2) == 0);
      if (!dc_pend && ($urandom_range(0, 1) == 1)) begin
        dc_pend = 1;
        dc_type = req_type_t'($urandom_range(0, 1));
        dc_addr = rand_addr();
        dc_data = rand_data();
      end
      if (!ic_v && !dc_pend) ic_v = 1;
      if (ic_v) ic_addr = rand_addr();
      inj_k    = $urandom_range(0, L - 1);
      inj_type = req_type_t'($urandom_range(0, 1));
      inj_addr = rand_addr();
      inj_data = rand_data();
      serve_one();
    end
    if (dc_pend) begin
      ic_v = 0;
      serve_one();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_simple.md
Name: mem_ctrl_simple

Overview:
Responder end of the cache-to-memory-controller block protocol. Arbitrates block requests from the icache (read-only) and the dcache (read/write), with icache priority. Services one request at a time against an internal main-memory block array after a fixed latency, then returns a one-cycle response pulse to the requester that issued it. Sits between both L1 caches and the top level; acts as the main-memory model for simulation.

Parameters:
- N_BLOCKS, 1024: number of main-memory blocks.
- BLOCK_WIDTH, 64: bits per block (block_data_t).
- ADDR_WIDTH, $clog2(N_BLOCKS): block address width (main_mem_block_addr_t).
- MEM_LATENCY, 10: cycles from request acceptance to response pulse; must be ≥ 2.

Ports:
- clk, input, 1: clock.
- rst_aL, input, 1: synchronous, active-low reset.
- icache_req_valid, input, 1: icache read request.
- icache_req_block_addr, input, ADDR_WIDTH: icache block address.
- icache_req_ready, output, 1: controller accepts icache request this cycle.
- icache_resp_valid, output, 1: one-cycle pulse carrying icache read data.
- icache_resp_block_data, output, BLOCK_WIDTH: icache read data.
- dcache_req_valid, input, 1: dcache request.
- dcache_req_type, input, 1 (req_type_t): 0 read, 1 write.
- dcache_req_block_addr, input, ADDR_WIDTH: dcache block address.
- dcache_req_block_data, input, BLOCK_WIDTH: write data (ignored on reads).
- dcache_req_ready, output, 1: controller accepts dcache request this cycle.
- dcache_resp_valid, output, 1: one-cycle pulse; read data, or write acknowledge.
- dcache_resp_block_data, output, BLOCK_WIDTH: read data; on a write, echoes the written block.

Behaviour:
- Clock and reset: one clock, clk. rst_aL is synchronous and active-low; reset is sampled on the clk rising edge.
- Reset: state = IDLE, counter = 0, all ready/valid outputs = 0, data outputs = 0. Memory array contents are not reset (testbench preloads them hierarchically).
- FSM states:
  - IDLE → BUSY on acceptance.
  - BUSY → RESP when the counter reaches 0.
  - RESP → IDLE unconditionally.
- Ready rules:
  - icache_req_ready = (state == IDLE).
  - dcache_req_ready = (state == IDLE) && !icache_req_valid. Icache wins every tie.
  - Both readies are combinational from state and inputs. Neither is asserted outside IDLE.
- Acceptance (valid && ready at edge T):
  - Latch requester id (0 = icache, 1 = dcache), type (icache is always read), address and write data.
  - Load the counter with MEM_LATENCY-2.
- BUSY: decrement the counter each cycle. Requests arriving now are held off (ready = 0); requesters must hold valid and fields stable until accepted.
- Commit on the BUSY → RESP edge:
  - Read: fetch mem[addr] into the response register.
  - Write: mem[addr] ← latched data; the response register gets the latched data.
- RESP: exactly one of icache_resp_valid / dcache_resp_valid is high for one cycle, chosen by the latched id, with data valid the same cycle. No resp_ready exists; the requester must sink the pulse.
- Latency: accepted at edge T → resp_valid high in cycle T+MEM_LATENCY (first cycle after T is BUSY).
- Back-to-back: the next request can be accepted no earlier than the cycle after the RESP cycle. Throughput is one request per MEM_LATENCY+1 cycles.
- Read-after-write to the same address returns the new data.
- Reset mid-operation: the transaction is aborted. A write not yet committed is lost, and no response is issued.
- Out-of-range addresses are not possible; address width is exact.

Decomposition:
- Shared package (global_defs): req_type_t (READ = 0, WRITE = 1), main_mem_block_addr_t, block_data_t, MEM_LATENCY default.
- One sub-module: main_mem_array, a synchronous single-port block RAM (N_BLOCKS × BLOCK_WIDTH) with write enable and registered read. The FSM, arbiter and latency counter stay in mem_ctrl_simple.

Test Plan:
1. Reset then idle: hold rst_aL = 0 for 2 cycles → all resp_valid = 0; icache_req_ready = 1 and dcache_req_ready = 1 in the first cycle after release with no valids.
2. Icache read: mem[5] preloaded 0xDEADBEEF_01234567; icache_req_valid with addr 5 accepted at cycle 10 → icache_resp_valid only at cycle 20 with that data; dcache_resp_valid stays 0.
3. Dcache write then read: write 0xA5A5… to addr 1023 → dcache_resp_valid after 10 cycles, echoing the data. Then read addr 1023 → returns 0xA5A5….
4. Simultaneous requests: icache (addr 3) and dcache (addr 4) valid in the same IDLE cycle → icache accepted first, dcache_req_ready = 0. Dcache is accepted in the cycle after the icache RESP cycle; its response arrives 10 cycles later.
5. Held-off request: dcache valid asserted during BUSY → ready stays 0 until IDLE; request is not lost; memory state matches a single write.
6. Reset mid-write: dcache write to addr 7 accepted, rst_aL = 0 at cycle +5 → no dcache_resp_valid; mem[7] unchanged after reset release.
